fifo_mem_prog: RTL and testbench

FIFO_MEM_PROG -- requirements
Module: fifo_mem_prog

---
 rtl/fifo_mem_prog.sv | 93 +++++++++
 tb/tb_fifo_mem_prog.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_mem_prog.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds and sticky error flags.
// Define FIFO_MEM_PROG_FWFT_EN for first-word fall-through read data; default is registered read data.
module fifo_mem_prog #(
  parameter int DATA_WIDTH = 16,
  parameter int OSTD_NUM   = 18,
  localparam int CNT_WIDTH = $clog2(OSTD_NUM + 1)
) (
  input  logic                  clk_in,
  input  logic                  sreset,
  input  logic                  trans_write,
  input  logic                  trans_read,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [CNT_WIDTH-1:0]  thr_full_lvl,
  input  logic [CNT_WIDTH-1:0]  thr_empty_lvl,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [CNT_WIDTH-1:0]  fill_cnt,
  output logic                  full_ind,
  output logic                  empty_ind,
  output logic                  almost_full_ind,
  output logic                  almost_empty_ind,
  output logic                  overflow_ind,
  output logic                  underflow_ind
);

  localparam int PTR_WIDTH = (OSTD_NUM > 1) ? $clog2(OSTD_NUM) : 1;
  localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(OSTD_NUM - 1);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(OSTD_NUM);

  logic [DATA_WIDTH-1:0] mem [OSTD_NUM];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;

  // Full takes precedence over a simultaneous read: no write-through when full.
  assign wr_acc = trans_write & ~full_ind;
  assign rd_acc = trans_read  & ~empty_ind;

  assign full_ind         = (fill_cnt == FULL_CNT);
  assign empty_ind        = (fill_cnt == '0);
  assign almost_full_ind  = (fill_cnt >= thr_full_lvl);
  assign almost_empty_ind = (fill_cnt <= thr_empty_lvl);

  always_ff @(posedge clk_in) begin
    if (wr_acc && !sreset) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (sreset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fill_cnt      <= '0;
      overflow_ind  <= 1'b0;
      underflow_ind <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   fill_cnt <= fill_cnt + 1'b1;
        2'b01:   fill_cnt <= fill_cnt - 1'b1;
        default: fill_cnt <= fill_cnt;
      endcase
      // A new error in the clearing cycle keeps the flag set.
      overflow_ind  <= (overflow_ind  & ~err_clr) | (trans_write & full_ind);
      underflow_ind <= (underflow_ind & ~err_clr) | (trans_read  & empty_ind);
    end
  end

`ifdef FIFO_MEM_PROG_FWFT_EN
  always_comb begin
    data_out = '0;
    if (!empty_ind) begin
      data_out = mem[rd_ptr];
    end
  end
`else
  always_ff @(posedge clk_in) begin
    if (sreset) begin
      data_out <= '0;
    end else if (rd_acc) begin
      data_out <= mem[rd_ptr];
    end
  end
`endif

endmodule

// File: tb/tb_fifo_mem_prog.sv
// Self-checking bench for fifo_mem_prog: queue-based reference model, read-data scoreboard,
// a table of short vectors, directed corner sequences and a random phase.
module tb_fifo_mem_prog;

  localparam int DW    = 16;
  localparam int DEPTH = 18;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk_in = 1'b0;
  logic          sreset = 1'b1;
  logic          trans_write = 1'b0;
  logic          trans_read = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [CW-1:0] thr_full_lvl = CW'(9);
  logic [CW-1:0] thr_empty_lvl = CW'(2);
  logic          err_clr = 1'b0;
  logic [DW-1:0] data_out;
  logic [CW-1:0] fill_cnt;
  logic          full_ind, empty_ind, almost_full_ind, almost_empty_ind;
  logic          overflow_ind, underflow_ind;

  fifo_mem_prog #(.DATA_WIDTH(DW), .OSTD_NUM(DEPTH)) dut (
    .clk_in          (clk_in),
    .sreset          (sreset),
    .trans_write     (trans_write),
    .trans_read      (trans_read),
    .data_in         (data_in),
    .thr_full_lvl    (thr_full_lvl),
    .thr_empty_lvl   (thr_empty_lvl),
    .err_clr         (err_clr),
    .data_out        (data_out),
    .fill_cnt        (fill_cnt),
    .full_ind        (full_ind),
    .empty_ind       (empty_ind),
    .almost_full_ind (almost_full_ind),
    .almost_empty_ind(almost_empty_ind),
    .overflow_ind    (overflow_ind),
    .underflow_ind   (underflow_ind)
  );

  always #5 clk_in = ~clk_in;

  int unsigned   n_cmp = 0;
  int unsigned   n_err = 0;
  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mdout = '0;
  bit            movf = 1'b0;
  bit            munf = 1'b0;

  typedef struct {
    bit            w;
    bit            r;
    bit            c;
    logic [DW-1:0] d;
    int            fill;
    bit            ovf;
    bit            unf;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    chk("fill_cnt", 32'(fill_cnt), 32'(mq.size()));
    chk("full_ind", 32'(full_ind), 32'(mq.size() == DEPTH));
    chk("empty_ind", 32'(empty_ind), 32'(mq.size() == 0));
    chk("almost_full", 32'(almost_full_ind), 32'(mq.size() >= 9));
    chk("almost_empty", 32'(almost_empty_ind), 32'(mq.size() <= 2));
    chk("overflow_ind", 32'(overflow_ind), 32'(movf));
    chk("underflow_ind", 32'(underflow_ind), 32'(munf));
`ifdef FIFO_MEM_PROG_FWFT_EN
    chk("data_out_fwft", 32'(data_out), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
`else
    if (exp_q.size() != 0) mdout = exp_q.pop_front();
    chk("data_out", 32'(data_out), 32'(mdout));
`endif
  endtask

  task automatic step(input bit w, input bit r, input bit c, input logic [DW-1:0] d);
    bit full_m, empty_m, wa, ra;
    trans_write = w;
    trans_read  = r;
    err_clr     = c;
    data_in     = d;
    full_m  = (mq.size() == DEPTH);
    empty_m = (mq.size() == 0);
    wa = w && !full_m;
    ra = r && !empty_m;
    if (ra) exp_q.push_back(mq[0]);
    @(posedge clk_in);
    #1;
    if (ra) void'(mq.pop_front());
    if (wa) mq.push_back(d);
    movf = (c ? 1'b0 : movf) | (w && full_m);
    munf = (c ? 1'b0 : munf) | (r && empty_m);
    trans_write = 1'b0;
    trans_read  = 1'b0;
    err_clr     = 1'b0;
    check_model();
  endtask

  task automatic do_reset();
    sreset = 1'b1;
    trans_write = 1'b1;
    trans_read  = 1'b1;
    @(posedge clk_in);
    #1;
    sreset = 1'b0;
    trans_write = 1'b0;
    trans_read  = 1'b0;
    mq.delete();
    exp_q.delete();
    mdout = '0;
    movf = 1'b0;
    munf = 1'b0;
    check_model();
  endtask

  initial begin
    tbl[0]  = '{w:0, r:1, c:0, d:16'h0000, fill:0, ovf:0, unf:1};
    tbl[1]  = '{w:0, r:0, c:1, d:16'h0000, fill:0, ovf:0, unf:0};
    tbl[2]  = '{w:1, r:0, c:0, d:16'h00A1, fill:1, ovf:0, unf:0};
    tbl[3]  = '{w:1, r:0, c:0, d:16'h00A2, fill:2, ovf:0, unf:0};
    tbl[4]  = '{w:1, r:1, c:0, d:16'h00A3, fill:2, ovf:0, unf:0};
    tbl[5]  = '{w:0, r:1, c:0, d:16'h0000, fill:1, ovf:0, unf:0};
    tbl[6]  = '{w:0, r:1, c:0, d:16'h0000, fill:0, ovf:0, unf:0};
    tbl[7]  = '{w:1, r:1, c:0, d:16'h00A4, fill:1, ovf:0, unf:1};
    tbl[8]  = '{w:0, r:1, c:1, d:16'h0000, fill:0, ovf:0, unf:0};
    tbl[9]  = '{w:0, r:1, c:1, d:16'h0000, fill:0, ovf:0, unf:1};
    tbl[10] = '{w:0, r:0, c:1, d:16'h0000, fill:0, ovf:0, unf:0};
    tbl[11] = '{w:1, r:0, c:0, d:16'h00B1, fill:1, ovf:0, unf:0};

    repeat (2) @(posedge clk_in);
    do_reset();

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].w, tbl[i].r, tbl[i].c, tbl[i].d);
      chk($sformatf("tbl%0d_fill", i), 32'(fill_cnt), 32'(tbl[i].fill));
      chk($sformatf("tbl%0d_ovf", i), 32'(overflow_ind), 32'(tbl[i].ovf));
      chk($sformatf("tbl%0d_unf", i), 32'(underflow_ind), 32'(tbl[i].unf));
    end

    // Fill to full, then overflow.
    do_reset();
    for (int i = 1; i <= DEPTH; i++) step(1, 0, 0, DW'(i));
    chk("fill_full", 32'(fill_cnt), 32'd18);
    chk("full_set", 32'(full_ind), 32'd1);
    step(1, 0, 0, 16'h0013);
    chk("ovf_set", 32'(overflow_ind), 32'd1);
    chk("fill_after_ovf", 32'(fill_cnt), 32'd18);

    // Drain in order, then underflow.
    for (int i = 1; i <= DEPTH; i++) begin
      step(0, 1, 0, '0);
`ifndef FIFO_MEM_PROG_FWFT_EN
      chk($sformatf("rd_order%0d", i), 32'(data_out), 32'(i));
`endif
    end
    chk("empty_after_drain", 32'(empty_ind), 32'd1);
    step(0, 1, 0, '0);
    chk("unf_set", 32'(underflow_ind), 32'd1);
`ifndef FIFO_MEM_PROG_FWFT_EN
    chk("dout_hold", 32'(data_out), 32'h12);
`endif
    step(0, 0, 1, '0);
    chk("clr_ovf", 32'(overflow_ind), 32'd0);
    chk("clr_unf", 32'(underflow_ind), 32'd0);

    // Pointer wrap: write 10, read 10, write 18, read 18.
    for (int i = 0; i < 10; i++) step(1, 0, 0, DW'(16'h0100 + i));
    for (int i = 0; i < 10; i++) step(0, 1, 0, '0);
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, DW'(16'h0200 + i));
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, '0);
    chk("wrap_ovf", 32'(overflow_ind), 32'd0);
    chk("wrap_unf", 32'(underflow_ind), 32'd0);

    // Simultaneous requests at fill 5 and at full.
    for (int i = 0; i < 5; i++) step(1, 0, 0, DW'(16'h0300 + i));
    step(1, 1, 0, 16'h0305);
    chk("both_fill5", 32'(fill_cnt), 32'd5);
    for (int i = 6; i < 19; i++) step(1, 0, 0, DW'(16'h0300 + i));
    chk("fill18_again", 32'(fill_cnt), 32'd18);
    step(1, 1, 0, 16'h03FF);
    chk("both_full_fill", 32'(fill_cnt), 32'd17);
    chk("both_full_ovf", 32'(overflow_ind), 32'd1);
    step(0, 0, 1, '0);
    chk("clr_after_both", 32'(overflow_ind), 32'd0);

    // Threshold edges.
    do_reset();
    for (int i = 0; i < 2; i++) step(1, 0, 0, DW'(16'h0400 + i));
    chk("ae_at2", 32'(almost_empty_ind), 32'd1);
    step(1, 0, 0, 16'h0402);
    chk("ae_at3", 32'(almost_empty_ind), 32'd0);
    for (int i = 3; i < 8; i++) step(1, 0, 0, DW'(16'h0400 + i));
    chk("af_at8", 32'(almost_full_ind), 32'd0);
    step(1, 0, 0, 16'h0408);
    chk("af_at9", 32'(almost_full_ind), 32'd1);

    // Reset at fill 7 with both sticky flags set.
    do_reset();
    step(0, 1, 0, '0);
    for (int i = 0; i < 19; i++) step(1, 0, 0, DW'(16'h0500 + i));
    for (int i = 0; i < 11; i++) step(0, 1, 0, '0);
    chk("pre_rst_fill", 32'(fill_cnt), 32'd7);
    chk("pre_rst_flags", {30'd0, overflow_ind, underflow_ind}, 32'd3);
    do_reset();
    chk("rst_fill", 32'(fill_cnt), 32'd0);
    chk("rst_empty", 32'(empty_ind), 32'd1);
    chk("rst_full", 32'(full_ind), 32'd0);
    chk("rst_flags", {30'd0, overflow_ind, underflow_ind}, 32'd0);
    chk("rst_dout", 32'(data_out), 32'd0);
    step(1, 0, 0, 16'h00AB);
`ifdef FIFO_MEM_PROG_FWFT_EN
    chk("fwft_first", 32'(data_out), 32'hAB);
`else
    chk("no_fwft_hold", 32'(data_out), 32'd0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0), DW'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
